// File: rtl/exc_writeback.sv
// Execute-to-writeback pipeline register with overflow redirection to the
// status register, a sticky exception flag and a saturating overflow counter.
module exc_writeback #(
  parameter int unsigned RSTATUS_REG = 30,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_wren,
  input  logic [4:0]       in_rd,
  input  logic [31:0]      in_result,
  input  logic             in_ovf,
  input  logic [31:0]      in_status,
  input  logic             wb_ready,
  output logic             ctrl_writeEnable,
  output logic [4:0]       ctrl_writeReg,
  output logic [31:0]      data_writeReg,
  output logic             exc_pending,
  input  logic             clr_exc,
  output logic [CNT_W-1:0] ovf_count
);

  localparam logic [4:0] RSTATUS_IDX = 5'(RSTATUS_REG);

  logic             full_q, full_d;
  logic             wren_q, wren_d;
  logic [4:0]       rd_q, rd_d;
  logic [31:0]      data_q, data_d;
  logic             ovf_q, ovf_d;
  logic             exc_q, exc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic retire;
  logic capture;

  // Reset gates in_ready so nothing is accepted while reset is held.
  assign retire   = full_q & wb_ready;
  assign in_ready = reset & (~full_q | wb_ready);
  assign capture  = in_valid & in_ready;

  always_comb begin
    full_d = full_q;
    wren_d = wren_q;
    rd_d   = rd_q;
    data_d = data_q;
    ovf_d  = ovf_q;
    exc_d  = exc_q;
    cnt_d  = cnt_q;

    if (retire) begin
      full_d = 1'b0;
    end

    if (capture) begin
      full_d = 1'b1;
      if (in_ovf) begin
        wren_d = 1'b1;
        rd_d   = RSTATUS_IDX;
        data_d = in_status;
        ovf_d  = 1'b1;
      end else begin
        wren_d = in_wren & (in_rd != 5'd0);
        rd_d   = in_rd;
        data_d = in_result;
        ovf_d  = 1'b0;
      end
    end

    // Set wins over clear when both happen in the same cycle.
    if (clr_exc) begin
      exc_d = 1'b0;
    end
    if (retire && ovf_q) begin
      exc_d = 1'b1;
      if (!(&cnt_q)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      full_q <= 1'b0;
      wren_q <= 1'b0;
      rd_q   <= '0;
      data_q <= '0;
      ovf_q  <= 1'b0;
      exc_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      full_q <= full_d;
      wren_q <= wren_d;
      rd_q   <= rd_d;
      data_q <= data_d;
      ovf_q  <= ovf_d;
      exc_q  <= exc_d;
      cnt_q  <= cnt_d;
    end
  end

  assign ctrl_writeEnable = full_q & wren_q & wb_ready;
  assign ctrl_writeReg    = full_q ? rd_q : 5'd0;
  assign data_writeReg    = full_q ? data_q : 32'd0;
  assign exc_pending      = exc_q;
  assign ovf_count        = cnt_q;

endmodule

// File: tb/tb_exc_writeback.sv
// Directed bench for exc_writeback; expected register-file writes are queued
// when stimulus is driven and compared as each write strobe appears.
module tb_exc_writeback;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_wren;
  logic [4:0]  in_rd;
  logic [31:0] in_result;
  logic        in_ovf;
  logic [31:0] in_status;
  logic        wb_ready;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic        exc_pending;
  logic        clr_exc;
  logic [7:0]  ovf_count;

  int n_assert = 0;
  int n_fail   = 0;

  logic [36:0] exp_q[$];

  exc_writeback #(.RSTATUS_REG(30), .CNT_W(8)) dut (
    .clock           (clock),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_wren         (in_wren),
    .in_rd           (in_rd),
    .in_result       (in_result),
    .in_ovf          (in_ovf),
    .in_status       (in_status),
    .wb_ready        (wb_ready),
    .ctrl_writeEnable(ctrl_writeEnable),
    .ctrl_writeReg   (ctrl_writeReg),
    .data_writeReg   (data_writeReg),
    .exc_pending     (exc_pending),
    .clr_exc         (clr_exc),
    .ovf_count       (ovf_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Drives one result; queues the expected write when the entry should write.
  task automatic drive(input logic wren, input logic [4:0] rd, input logic [31:0] res,
                       input logic ovf, input logic [31:0] status, input bit push);
    in_valid  = 1'b1;
    in_wren   = wren;
    in_rd     = rd;
    in_result = res;
    in_ovf    = ovf;
    in_status = status;
    if (push) begin
      if (ovf) exp_q.push_back({5'd30, status});
      else if (wren && rd != 5'd0) exp_q.push_back({rd, res});
    end
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    in_wren   = 1'b0;
    in_rd     = 5'd0;
    in_result = 32'd0;
    in_ovf    = 1'b1;
    in_status = 32'd0;
  endtask

  always @(negedge clock) begin
    if (ctrl_writeEnable) begin
      logic [36:0] e;
      n_assert++;
      assert (exp_q.size() > 0)
      else begin
        n_fail++;
        $error("FAIL wb_unexpected: observed write rd=%0d data=0x%0h expected none",
               ctrl_writeReg, data_writeReg);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("wb_rd", 32'(ctrl_writeReg), 32'(e[36:32]));
        chk("wb_data", data_writeReg, e[31:0]);
      end
    end
  end

  initial begin
    reset    = 1'b0;
    wb_ready = 1'b1;
    clr_exc  = 1'b0;
    idle();
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_we", 32'(ctrl_writeEnable), 32'd0);
    chk("rst_exc", 32'(exc_pending), 32'd0);
    chk("rst_cnt", 32'(ovf_count), 32'd0);

    cyc();
    reset = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // add r5 = 0x10
    drive(1'b1, 5'd5, 32'h10, 1'b0, 32'd1, 1'b1);
    cyc();
    idle();
    chk("add_we", 32'(ctrl_writeEnable), 32'd1);
    chk("add_rd", 32'(ctrl_writeReg), 32'd5);
    chk("add_data", data_writeReg, 32'h10);
    chk("add_cnt", 32'(ovf_count), 32'd0);
    cyc();
    chk("add_retired_we", 32'(ctrl_writeEnable), 32'd0);
    chk("add_retired_rd", 32'(ctrl_writeReg), 32'd0);

    // sub overflow to r7 redirected to r30 with status 3
    drive(1'b1, 5'd7, 32'hDEAD_BEEF, 1'b1, 32'd3, 1'b1);
    cyc();
    idle();
    chk("sub_ovf_we", 32'(ctrl_writeEnable), 32'd1);
    chk("sub_ovf_rd", 32'(ctrl_writeReg), 32'd30);
    chk("sub_ovf_data", data_writeReg, 32'd3);
    chk("sub_ovf_exc_before", 32'(exc_pending), 32'd0);
    cyc();
    chk("sub_ovf_exc", 32'(exc_pending), 32'd1);
    chk("sub_ovf_cnt", 32'(ovf_count), 32'd1);

    clr_exc = 1'b1;
    cyc();
    clr_exc = 1'b0;
    chk("clr_exc", 32'(exc_pending), 32'd0);
    chk("clr_cnt_kept", 32'(ovf_count), 32'd1);

    // stall with a second result waiting
    wb_ready = 1'b0;
    drive(1'b1, 5'd9, 32'h99, 1'b0, 32'd0, 1'b1);
    cyc();
    drive(1'b1, 5'd10, 32'hAA, 1'b0, 32'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_we", 32'(ctrl_writeEnable), 32'd0);
      chk("stall_rd", 32'(ctrl_writeReg), 32'd9);
      chk("stall_data", data_writeReg, 32'h99);
      cyc();
    end
    wb_ready = 1'b1;
    #1;
    chk("unstall_in_ready", 32'(in_ready), 32'd1);
    chk("unstall_we", 32'(ctrl_writeEnable), 32'd1);
    cyc();
    idle();
    chk("next_we", 32'(ctrl_writeEnable), 32'd1);
    chk("next_rd", 32'(ctrl_writeReg), 32'd10);
    chk("next_data", data_writeReg, 32'hAA);
    cyc();

    // write to r0 is suppressed
    drive(1'b1, 5'd0, 32'h55, 1'b0, 32'd0, 1'b1);
    cyc();
    idle();
    chk("r0_we", 32'(ctrl_writeEnable), 32'd0);
    chk("r0_in_ready", 32'(in_ready), 32'd1);
    chk("r0_data", data_writeReg, 32'h55);
    cyc();

    // wren=0 suppresses the write
    drive(1'b0, 5'd3, 32'h77, 1'b0, 32'd0, 1'b1);
    cyc();
    idle();
    chk("nowren_we", 32'(ctrl_writeEnable), 32'd0);
    cyc();

    // 256 back-to-back addi overflows; clear collides with the last retirement
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 5'd4, 32'(i), 1'b1, 32'd2, 1'b1);
      cyc();
    end
    idle();
    clr_exc = 1'b1;
    cyc();
    clr_exc = 1'b0;
    chk("sat_cnt", 32'(ovf_count), 32'hFF);
    chk("set_beats_clr", 32'(exc_pending), 32'd1);

    // reset while an entry is stalled
    wb_ready = 1'b0;
    drive(1'b1, 5'd12, 32'h1234, 1'b0, 32'd0, 1'b0);
    cyc();
    idle();
    chk("prerst_rd", 32'(ctrl_writeReg), 32'd12);
    #2;
    reset    = 1'b0;
    wb_ready = 1'b1;
    #1;
    chk("midrst_we", 32'(ctrl_writeEnable), 32'd0);
    chk("midrst_rd", 32'(ctrl_writeReg), 32'd0);
    chk("midrst_data", data_writeReg, 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    chk("midrst_exc", 32'(exc_pending), 32'd0);
    chk("midrst_cnt", 32'(ovf_count), 32'd0);
    cyc();
    reset = 1'b1;
    cyc();
    cyc();
    chk("postrst_we", 32'(ctrl_writeEnable), 32'd0);
    chk("postrst_rd", 32'(ctrl_writeReg), 32'd0);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
